// File: rtl/input_read_sched_pkg.sv
// Shared types, widths and config-field helpers for the input read scheduler.
package input_read_sched_pkg;

  localparam int unsigned COUNTER_WIDTH  = 32;
  localparam int unsigned NUM_PARAMS     = 8;
  localparam int unsigned TILE_CNT_WIDTH = 16;
  localparam int unsigned CFG_WIDTH      = NUM_PARAMS * COUNTER_WIDTH;

  // Field order inside the packed config word; OX0 occupies the MSBs.
  localparam int unsigned OX0_IDX    = 0;
  localparam int unsigned OY0_IDX    = 1;
  localparam int unsigned FX_IDX     = 2;
  localparam int unsigned FY_IDX     = 3;
  localparam int unsigned STRIDE_IDX = 4;
  localparam int unsigned IX0_IDX    = 5;
  localparam int unsigned IY0_IDX    = 6;
  localparam int unsigned IC1_IDX    = 7;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    CALC      = 3'd2,
    WAIT_BANK = 3'd3,
    READ      = 3'd4,
    DONE      = 3'd5
  } sched_state_e;

  function automatic logic [COUNTER_WIDTH-1:0] cfg_field(input logic [CFG_WIDTH-1:0] data,
                                                         input int unsigned idx);
    return data[(NUM_PARAMS - 1 - idx) * COUNTER_WIDTH +: COUNTER_WIDTH];
  endfunction

endpackage

// File: rtl/input_read_scheduler_counter.sv
// Up-counter with synchronous clear, enable and a terminal-count compare (sched_counter).
module sched_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] term_i,
  output logic             at_term_o
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign at_term_o = (count_q == term_i);

endmodule

// File: rtl/input_read_scheduler.sv
// Per-layer sequencer for the input address generator: config load, read-count calc, per-tile reads.
// Optional READ_SCHED_PERF_EN adds saturating stall / bank-wait cycle counters.
module input_read_scheduler
  import input_read_sched_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [CFG_WIDTH-1:0]      cfg_data,
  input  logic [TILE_CNT_WIDTH-1:0] cfg_num_tiles,
  input  logic                      bank_full,
  output logic                      bank_release,
  input  logic                      read_stall,
  output logic                      agen_config_enable,
  output logic [CFG_WIDTH-1:0]      agen_config_data,
  output logic                      agen_addr_enable,
  output logic                      tile_done,
  output logic                      layer_done,
  output logic                      cfg_error
`ifdef READ_SCHED_PERF_EN
  ,
  output logic [COUNTER_WIDTH-1:0]  perf_stall_cycles,
  output logic [COUNTER_WIDTH-1:0]  perf_wait_cycles
`endif
);

  sched_state_e state_q, state_d;

  logic [CFG_WIDTH-1:0]      cfg_q;
  logic [TILE_CNT_WIDTH-1:0] tiles_q;
  logic [1:0]                calc_step_q;
  logic [COUNTER_WIDTH-1:0]  prod_q, prod_d, mul_a_c, mul_b_c;
  logic [COUNTER_WIDTH-1:0]  read_term_c, tile_term_c;
  logic cfg_ready_q, cfg_ready_d, cfg_en_q, cfg_en_d;
  logic layer_done_q, layer_done_d, cfg_error_q, cfg_error_d;
  logic accept_c, calc_last_c, zero_cfg_c, read_en_c, last_read_c;
  logic read_at_term_c, tile_at_term_c;

  assign accept_c    = (state_q == IDLE) && cfg_valid;
  assign calc_last_c = (state_q == CALC) && (calc_step_q == 2'd3);
  assign zero_cfg_c  = (cfg_field(cfg_q, OX0_IDX) == '0) || (cfg_field(cfg_q, OY0_IDX) == '0) ||
                       (cfg_field(cfg_q, FX_IDX) == '0)  || (cfg_field(cfg_q, FY_IDX) == '0)  ||
                       (cfg_field(cfg_q, IC1_IDX) == '0) || (tiles_q == '0);
  assign read_en_c   = (state_q == READ) && !read_stall;
  assign last_read_c = read_en_c && read_at_term_c;
  assign read_term_c = prod_q - COUNTER_WIDTH'(1);
  assign tile_term_c = COUNTER_WIDTH'(tiles_q) - COUNTER_WIDTH'(1);

  // Single shared multiplier: step 0 seeds with OX0*OY0, later steps fold in FX, FY, IC1.
  always_comb begin
    mul_a_c = (calc_step_q == 2'd0) ? cfg_field(cfg_q, OX0_IDX) : prod_q;
    mul_b_c = cfg_field(cfg_q, OY0_IDX);
    case (calc_step_q)
      2'd0:    mul_b_c = cfg_field(cfg_q, OY0_IDX);
      2'd1:    mul_b_c = cfg_field(cfg_q, FX_IDX);
      2'd2:    mul_b_c = cfg_field(cfg_q, FY_IDX);
      default: mul_b_c = cfg_field(cfg_q, IC1_IDX);
    endcase
    prod_d = prod_q;
    if (state_q == CALC) begin
      prod_d = mul_a_c * mul_b_c;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (accept_c) state_d = LOAD;
      LOAD:      state_d = CALC;
      CALC:      if (calc_last_c) state_d = zero_cfg_c ? IDLE : WAIT_BANK;
      WAIT_BANK: if (bank_full) state_d = READ;
      READ:      if (last_read_c) state_d = tile_at_term_c ? DONE : WAIT_BANK;
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
    cfg_ready_d  = (state_d == IDLE);
    cfg_en_d     = (state_d == LOAD);
    layer_done_d = (state_d == DONE);
    cfg_error_d  = cfg_error_q;
    if (accept_c) begin
      cfg_error_d = 1'b0;
    end else if (calc_last_c && zero_cfg_c) begin
      cfg_error_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cfg_ready_q  <= 1'b1;
      cfg_en_q     <= 1'b0;
      layer_done_q <= 1'b0;
      cfg_error_q  <= 1'b0;
      cfg_q        <= '0;
      tiles_q      <= '0;
      calc_step_q  <= '0;
      prod_q       <= '0;
    end else begin
      state_q      <= state_d;
      cfg_ready_q  <= cfg_ready_d;
      cfg_en_q     <= cfg_en_d;
      layer_done_q <= layer_done_d;
      cfg_error_q  <= cfg_error_d;
      calc_step_q  <= (state_q == CALC) ? calc_step_q + 2'd1 : 2'd0;
      prod_q       <= prod_d;
      if (accept_c) begin
        cfg_q   <= cfg_data;
        tiles_q <= cfg_num_tiles;
      end
    end
  end

  // Read index restarts at every tile; tile index restarts at every layer.
  sched_counter #(.WIDTH(COUNTER_WIDTH)) u_read_cnt (
    .clk_i     (clk),
    .rst_i     (rst),
    .clr_i     (state_q != READ),
    .en_i      (read_en_c),
    .term_i    (read_term_c),
    .at_term_o (read_at_term_c)
  );

  sched_counter #(.WIDTH(COUNTER_WIDTH)) u_tile_cnt (
    .clk_i     (clk),
    .rst_i     (rst),
    .clr_i     (state_q == IDLE),
    .en_i      (last_read_c),
    .term_i    (tile_term_c),
    .at_term_o (tile_at_term_c)
  );

`ifdef READ_SCHED_PERF_EN
  logic [COUNTER_WIDTH-1:0] perf_stall_q, perf_wait_q;

  always_ff @(posedge clk) begin
    if (rst || accept_c) begin
      perf_stall_q <= '0;
      perf_wait_q  <= '0;
    end else begin
      if ((state_q == READ) && read_stall && (perf_stall_q != '1)) begin
        perf_stall_q <= perf_stall_q + COUNTER_WIDTH'(1);
      end
      if ((state_q == WAIT_BANK) && (perf_wait_q != '1)) begin
        perf_wait_q <= perf_wait_q + COUNTER_WIDTH'(1);
      end
    end
  end

  assign perf_stall_cycles = perf_stall_q;
  assign perf_wait_cycles  = perf_wait_q;
`endif

  assign cfg_ready          = cfg_ready_q;
  assign agen_config_enable = cfg_en_q;
  assign agen_config_data   = cfg_q;
  assign layer_done         = layer_done_q;
  assign cfg_error          = cfg_error_q;
  assign agen_addr_enable   = read_en_c;
  assign bank_release       = last_read_c;
  assign tile_done          = last_read_c;

endmodule

// File: tb/tb_input_read_scheduler.sv
// Scoreboard bench for input_read_scheduler: expected events queued at config accept, popped by a monitor.
module tb_input_read_scheduler;
  import input_read_sched_pkg::*;

  logic clk = 1'b0;
  logic rst, cfg_valid, cfg_ready, bank_full, bank_release, read_stall;
  logic agen_config_enable, agen_addr_enable, tile_done, layer_done, cfg_error;
  logic [CFG_WIDTH-1:0]      cfg_data, agen_config_data;
  logic [TILE_CNT_WIDTH-1:0] cfg_num_tiles;
`ifdef READ_SCHED_PERF_EN
  logic [COUNTER_WIDTH-1:0]  perf_stall_cycles, perf_wait_cycles;
`endif

  always #5 clk = ~clk;

  input_read_scheduler dut (
    .clk                (clk),
    .rst                (rst),
    .cfg_valid          (cfg_valid),
    .cfg_ready          (cfg_ready),
    .cfg_data           (cfg_data),
    .cfg_num_tiles      (cfg_num_tiles),
    .bank_full          (bank_full),
    .bank_release       (bank_release),
    .read_stall         (read_stall),
    .agen_config_enable (agen_config_enable),
    .agen_config_data   (agen_config_data),
    .agen_addr_enable   (agen_addr_enable),
    .tile_done          (tile_done),
    .layer_done         (layer_done),
    .cfg_error          (cfg_error)
`ifdef READ_SCHED_PERF_EN
    ,
    .perf_stall_cycles  (perf_stall_cycles),
    .perf_wait_cycles   (perf_wait_cycles)
`endif
  );

  typedef enum int {EV_CFG, EV_TILE, EV_LAYER, EV_ERR} ev_kind_e;
  typedef struct {
    ev_kind_e             kind;
    logic [CFG_WIDTH-1:0] data;
    int unsigned          val;
  } ev_t;

  ev_t sb[$];
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  int unsigned cyc = 0;
  int unsigned bank_mode = 0;
  int unsigned stall_pct = 0;

  int unsigned mon_reads = 0, mon_tiles = 0, first_en_cyc = 0, mon_last_dur = 0;
  int unsigned mon_last_tile_cyc = 32'hFFFF_FFFF, mon_layer_done_cyc = 0;
  bit busy = 0, prev_err = 0, gap_armed = 0, first_en_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic pop_ev(output ev_t e, output bit ok, input string who);
    e.kind = EV_ERR;
    e.data = '0;
    e.val  = 0;
    ok     = 0;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_%s: got a DUT event expected none (cycle %0d)", who, cyc);
    end else begin
      e  = sb.pop_front();
      ok = 1;
    end
  endtask

  // Monitor: samples on the falling edge and retires scoreboard events.
  always @(negedge clk) begin : monitor
    ev_t e;
    bit  ok;
    if (rst) begin
      mon_reads = 0; mon_tiles = 0; busy = 0; prev_err = 0; gap_armed = 0; first_en_seen = 0;
    end else begin
      if (cfg_error && !prev_err) busy = 0;
      check("cfg_ready", 64'(cfg_ready), 64'(!busy));
      if (read_stall) check("stall_gate", 64'(agen_addr_enable), 64'(0));
      if (agen_addr_enable) begin
        mon_reads++;
        if (!first_en_seen) begin
          first_en_seen = 1;
          first_en_cyc  = cyc;
        end
        if (gap_armed) begin
          gap_armed = 0;
          check("bank_gap", 64'(cyc - mon_last_tile_cyc), 64'(11));
        end
      end
      if (bank_release || tile_done) check("release_eq_tile", 64'(bank_release), 64'(tile_done));
      if (tile_done) begin
        check("tile_on_read", 64'(agen_addr_enable), 64'(1));
        pop_ev(e, ok, "tile");
        if (ok) begin
          check("tile_kind", 64'(e.kind), 64'(EV_TILE));
          check("tile_reads", 64'(mon_reads), 64'(e.val));
        end
        mon_last_dur      = cyc - first_en_cyc;
        mon_last_tile_cyc = cyc;
        mon_reads         = 0;
        first_en_seen     = 0;
        mon_tiles++;
        gap_armed = (bank_mode == 1) && (stall_pct == 0);
      end
      if (agen_config_enable) begin
        pop_ev(e, ok, "cfg");
        if (ok) begin
          check("cfg_kind", 64'(e.kind), 64'(EV_CFG));
          check("cfg_data", 64'(agen_config_data == e.data), 64'(1));
        end
        mon_reads = 0; mon_tiles = 0; first_en_seen = 0; gap_armed = 0;
      end
      if (layer_done) begin
        pop_ev(e, ok, "layer");
        if (ok) begin
          check("layer_kind", 64'(e.kind), 64'(EV_LAYER));
          check("layer_tiles", 64'(mon_tiles), 64'(e.val));
        end
        check("layer_latency", 64'(cyc - mon_last_tile_cyc), 64'(1));
        mon_layer_done_cyc = cyc;
        busy      = 0;
        gap_armed = 0;
      end
      if (cfg_error && !prev_err) begin
        pop_ev(e, ok, "error");
        if (ok) check("err_kind", 64'(e.kind), 64'(EV_ERR));
      end
      if (cfg_ready && cfg_valid) busy = 1;
      prev_err = cfg_error;
    end
  end

  // Bank-fill side: always full, refill 10 cycles after each release, or random level.
  initial begin
    bank_full = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (bank_mode)
        0: bank_full = 1'b1;
        1: begin
          if (mon_last_tile_cyc == cyc - 1) begin
            bank_full = 1'b0;
            repeat (9) begin @(posedge clk); #1; end
          end
          bank_full = 1'b1;
        end
        default: bank_full = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (stall_pct != 0) read_stall = ($urandom_range(0, 99) < stall_pct);
    end
  end

  task automatic send_cfg(input int unsigned ox, input int unsigned oy, input int unsigned fx,
                          input int unsigned fy, input int unsigned ic, input int unsigned tiles,
                          output int unsigned acc_cyc);
    logic [CFG_WIDTH-1:0] d;
    int unsigned total;
    bit err, accepted;
    ev_t e;
    d = {ox, oy, fx, fy, $urandom(), $urandom(), $urandom(), ic};
    total = ox * oy * fx * fy * ic;
    err = (ox == 0) || (oy == 0) || (fx == 0) || (fy == 0) || (ic == 0) || (tiles == 0);
    cfg_data      = d;
    cfg_num_tiles = TILE_CNT_WIDTH'(tiles);
    cfg_valid     = 1'b1;
    accepted = 0;
    acc_cyc  = 0;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if (cfg_ready) begin
        accepted = 1;
        break;
      end
    end
    if (!accepted) begin
      check("accept_timeout", 64'(0), 64'(1));
    end else begin
      acc_cyc = cyc;
      e.kind = EV_CFG; e.data = d; e.val = 0;
      sb.push_back(e);
      e.data = '0;
      if (err) begin
        e.kind = EV_ERR;
        sb.push_back(e);
      end else begin
        for (int t = 0; t < int'(tiles); t++) begin
          e.kind = EV_TILE; e.val = total;
          sb.push_back(e);
        end
        e.kind = EV_LAYER; e.val = tiles;
        sb.push_back(e);
      end
    end
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    if (accepted) check("err_clear_on_accept", 64'(cfg_error), 64'(0));
  endtask

  task automatic wait_drain(input int unsigned budget);
    for (int i = 0; i < int'(budget); i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    if (sb.size() != 0) begin
      check("drain_timeout", 64'(sb.size()), 64'(0));
      sb.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_reads(input int unsigned n);
    for (int i = 0; i < 3000; i++) begin
      if (mon_reads >= n) break;
      @(posedge clk); #1;
    end
    if (mon_reads < n) check("reads_timeout", 64'(mon_reads), 64'(n));
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin : driver
    int unsigned acc, acc_b, tiles;
    int unsigned v[5];
    rst = 1'b1; cfg_valid = 1'b0; cfg_data = '0; cfg_num_tiles = '0; read_stall = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cfg_ready", 64'(cfg_ready), 64'(1));
    check("rst_cfg_en", 64'(agen_config_enable), 64'(0));
    check("rst_addr_en", 64'(agen_addr_enable), 64'(0));
    check("rst_release", 64'(bank_release), 64'(0));
    check("rst_layer_done", 64'(layer_done), 64'(0));
    check("rst_cfg_error", 64'(cfg_error), 64'(0));
    check("rst_cfg_data", 64'(agen_config_data == '0), 64'(1));
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    send_cfg(3, 3, 3, 3, 2, 1, acc);
    wait_drain(2000);

    bank_mode = 1;
    send_cfg(3, 3, 3, 3, 2, 2, acc);
    wait_drain(3000);

    bank_mode = 0;
    send_cfg(3, 3, 3, 3, 2, 1, acc);
    wait_reads(50);
    read_stall = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    read_stall = 1'b0;
    wait_drain(2000);
    check("stall_tile_duration", 64'(mon_last_dur), 64'(166));

    send_cfg(3, 3, 0, 3, 2, 1, acc);
    wait_drain(200);
    check("zero_fx_error", 64'(cfg_error), 64'(1));
    check("zero_fx_ready", 64'(cfg_ready), 64'(1));
    send_cfg(3, 3, 3, 3, 2, 1, acc);
    wait_drain(2000);

    send_cfg(3, 3, 3, 3, 2, 2, acc);
    wait_reads(80);
    rst = 1'b1;
    sb.delete();
    @(posedge clk);
    @(negedge clk);
    check("midrst_cfg_ready", 64'(cfg_ready), 64'(1));
    check("midrst_addr_en", 64'(agen_addr_enable), 64'(0));
    check("midrst_release", 64'(bank_release), 64'(0));
    check("midrst_layer_done", 64'(layer_done), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    send_cfg(3, 3, 3, 3, 2, 1, acc);
    wait_drain(2000);

    send_cfg(1, 1, 1, 1, 1, 3, acc);
    send_cfg(3, 3, 3, 3, 2, 1, acc_b);
    check("b2b_accept_cycle", 64'(acc_b), 64'(mon_layer_done_cyc + 1));
    wait_drain(2000);

    bank_mode = 2;
    stall_pct = 25;
    for (int l = 0; l < 30; l++) begin
      for (int k = 0; k < 5; k++) v[k] = ($urandom_range(0, 11) == 0) ? 0 : $urandom_range(1, 3);
      tiles = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 3);
      send_cfg(v[0], v[1], v[2], v[3], v[4], tiles, acc);
      wait_drain(8000);
    end

    stall_pct = 0;
    read_stall = 1'b0;
    bank_mode = 0;
    repeat (5) @(posedge clk);
    check("scoreboard_empty", 64'(sb.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
